// File: rtl/dispatch_pkg.sv
// Shared defaults, typedefs and FSM state encoding for the interrupt dispatcher.
package dispatch_pkg;

  localparam int unsigned NumIrq     = 8;
  localparam int unsigned PrioWidth  = 8;
  localparam int unsigned StackDepth = 4;
  localparam int unsigned IdWidth    = $clog2(NumIrq);

  typedef logic [PrioWidth-1:0] Prio;
  typedef logic [IdWidth-1:0]   IrqId;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/tree.sv
// Combinational priority selector: returns the largest input value and its index.
// Ties resolve to the highest index.
module tree #(
  parameter int unsigned TreeWidth = 8,
  parameter type         TreeVal   = logic [7:0],
  parameter type         TreeIdx   = logic [2:0]
) (
  input  TreeVal vals_i [TreeWidth],
  output TreeVal max_o,
  output TreeIdx idx_o
);

  // Linear scan; >= lets a later (higher) index take over on equal values.
  always_comb begin
    max_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < TreeWidth; i++) begin
      if (vals_i[i] >= max_o) begin
        max_o = vals_i[i];
        idx_o = TreeIdx'(i);
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Nested interrupt dispatcher: latches pending lines, selects the highest enabled
// pending priority, offers it to the core only when it preempts the running level,
// and tracks nesting on an inline priority stack.
// Build option: define IRQ_DISPATCH_EDGE_EN for rising-edge sources (default: level).
module irq_dispatch #(
  parameter int unsigned NumIrq     = dispatch_pkg::NumIrq,
  parameter int unsigned PrioWidth  = dispatch_pkg::PrioWidth,
  parameter int unsigned StackDepth = dispatch_pkg::StackDepth
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NumIrq-1:0]                   irq_i,
  input  logic [NumIrq-1:0]                   en_i,
  input  logic [NumIrq-1:0][PrioWidth-1:0]    prio_i,
  input  logic [PrioWidth-1:0]                thresh_i,
  output logic                                req_valid_o,
  output logic [$clog2(NumIrq)-1:0]           req_id_o,
  output logic [PrioWidth-1:0]                req_prio_o,
  input  logic                                req_ready_i,
  input  logic                                ret_i,
  output logic [PrioWidth-1:0]                level_o,
  output logic [$clog2(StackDepth+1)-1:0]     depth_o,
  output logic [NumIrq-1:0]                   pend_o,
  output logic                                ret_err_o
);

  import dispatch_pkg::*;

  localparam int unsigned DepthW = $clog2(StackDepth + 1);
  localparam int unsigned SlotW  = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  typedef logic [DepthW-1:0] depth_t;
  typedef logic [SlotW-1:0]  slot_t;

  localparam depth_t DepthOne = depth_t'(1);
  localparam depth_t DepthMax = depth_t'(StackDepth);

  state_e            state_q;
  IrqId              req_id_q;
  Prio               req_prio_q;
  logic [NumIrq-1:0] pend_q, pend_set, pend_clr;
  Prio               stack_q [StackDepth];
  depth_t            depth_q;
  logic              ret_err_q;

  Prio  tree_vals [NumIrq];
  Prio  win_prio;
  IrqId win_id;
  Prio  level;
  logic taken, ret_ok, launch;

`ifdef IRQ_DISPATCH_EDGE_EN
  logic [NumIrq-1:0] irq_q, irq_qq;

  // Register the raw lines twice; the edge is detected between the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      irq_qq <= '0;
    end else begin
      irq_q  <= irq_i;
      irq_qq <= irq_q;
    end
  end

  assign pend_set = irq_q & ~irq_qq;
`else
  assign pend_set = irq_i;
`endif

  // Masked priorities feeding the selector; disabled or idle lines read as 0.
  always_comb begin
    for (int unsigned i = 0; i < NumIrq; i++) begin
      tree_vals[i] = (pend_q[i] & en_i[i]) ? prio_i[i] : '0;
    end
  end

  tree #(
    .TreeWidth (NumIrq),
    .TreeVal   (Prio),
    .TreeIdx   (IrqId)
  ) u_tree (
    .vals_i (tree_vals),
    .max_o  (win_prio),
    .idx_o  (win_id)
  );

  assign level  = (depth_q == '0) ? thresh_i : stack_q[slot_t'(depth_q - DepthOne)];
  assign taken  = (state_q == REQ) & req_ready_i;
  assign ret_ok = ret_i & (depth_q != '0);
  assign launch = (win_prio > level) && (win_prio != '0) && (depth_q < DepthMax);

  // One-hot clear of the line being taken.
  always_comb begin
    pend_clr = '0;
    if (taken) pend_clr[req_id_q] = 1'b1;
  end

  // Dispatch FSM; id/prio latched on launch and held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_id_q   <= '0;
      req_prio_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q    <= REQ;
            req_id_q   <= win_id;
            req_prio_q <= win_prio;
          end
        end
        REQ:     if (req_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pending bits: a new event wins over the clear from a take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= (pend_q & ~pend_clr) | pend_set;
  end

  // Nesting stack: pop on return, push on take; both together replace the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < StackDepth; i++) stack_q[i] <= '0;
      depth_q   <= '0;
      ret_err_q <= 1'b0;
    end else begin
      ret_err_q <= ret_i & (depth_q == '0);
      if (ret_ok && taken) begin
        stack_q[slot_t'(depth_q - DepthOne)] <= req_prio_q;
      end else if (ret_ok) begin
        depth_q <= depth_q - DepthOne;
      end else if (taken) begin
        stack_q[slot_t'(depth_q)] <= req_prio_q;
        depth_q <= depth_q + DepthOne;
      end
    end
  end

  assign req_valid_o = (state_q == REQ);
  assign req_id_o    = req_id_q;
  assign req_prio_o  = req_prio_q;
  assign level_o     = level;
  assign depth_o     = depth_q;
  assign pend_o      = pend_q;
  assign ret_err_o   = ret_err_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios against hand-derived
// values plus a randomized run against a behavioural reference model.
module tb_irq_dispatch;

  localparam int N  = 8;
  localparam int PW = 8;
  localparam int SD = 4;
`ifdef IRQ_DISPATCH_EDGE_EN
  localparam int Lat      = 3;
  localparam bit EdgeMode = 1'b1;
`else
  localparam int Lat      = 2;
  localparam bit EdgeMode = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         irq = '0;
  logic [N-1:0]         en = '0;
  logic [N-1:0][PW-1:0] prio = '0;
  logic [PW-1:0]        thresh = '0;
  logic                 ready = 1'b0;
  logic                 ret = 1'b0;
  logic                 req_valid;
  logic [2:0]           req_id;
  logic [PW-1:0]        req_prio;
  logic [PW-1:0]        level;
  logic [2:0]           depth;
  logic [N-1:0]         pend;
  logic                 ret_err;

  int n_cmp = 0;
  int n_bad = 0;

  irq_dispatch #(
    .NumIrq     (N),
    .PrioWidth  (PW),
    .StackDepth (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq),
    .en_i        (en),
    .prio_i      (prio),
    .thresh_i    (thresh),
    .req_valid_o (req_valid),
    .req_id_o    (req_id),
    .req_prio_o  (req_prio),
    .req_ready_i (ready),
    .ret_i       (ret),
    .level_o     (level),
    .depth_o     (depth),
    .pend_o      (pend),
    .ret_err_o   (ret_err)
  );

  always #5 clk = ~clk;

  // Reference model: pending set, stack as a queue, offered request as plain values.
  bit   [N-1:0]  m_pend;
  bit   [N-1:0]  m_s1, m_s2;
  logic [PW-1:0] m_stack[$];
  bit            m_valid;
  logic [2:0]    m_id;
  logic [PW-1:0] m_prio;
  bit            m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_s1 = '0; m_s2 = '0; m_stack.delete();
      m_valid = 0; m_id = '0; m_prio = '0; m_err = 0;
    end else begin
      int lvl, best, bid;
      bit tk, go;
      bit [N-1:0] setv;
      lvl  = (m_stack.size() == 0) ? int'(thresh) : int'(m_stack[$]);
      tk   = m_valid && ready;
      best = 0;
      bid  = 0;
      for (int i = 0; i < N; i++) begin
        int v;
        v = (m_pend[i] && en[i]) ? int'(prio[i]) : 0;
        if (v >= best) begin best = v; bid = i; end
      end
      go   = !m_valid && best > lvl && best != 0 && m_stack.size() < SD;
      setv = EdgeMode ? (m_s1 & ~m_s2) : irq;
      m_s2 = m_s1;
      m_s1 = irq;
      if (tk) m_pend[m_id] = 1'b0;
      m_pend = m_pend | setv;
      m_err  = ret && m_stack.size() == 0;
      if (ret && m_stack.size() > 0) void'(m_stack.pop_back());
      if (tk) m_stack.push_back(m_prio);
      if (tk) m_valid = 0;
      else if (go) begin m_valid = 1; m_id = 3'(bid); m_prio = PW'(best); end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; irq = '0; ready = 1'b0; ret = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse the given lines for one edge and wait (bounded) for a request.
  task automatic fire(input logic [N-1:0] mask, output int cyc);
    irq = mask;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      irq = '0;
    end while (!req_valid && cyc < 12);
  endtask

  task automatic take();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; thresh = 8'd9;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", req_valid); end
    n_cmp++; if (req_id !== 3'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", req_id); end
    n_cmp++; if (req_prio !== 8'd0) begin n_bad++; $display("FAIL reset_prio: got %0d want 0", req_prio); end
    n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_cmp++; if (pend !== 8'h00) begin n_bad++; $display("FAIL reset_pend: got %h want 00", pend); end
    n_cmp++; if (ret_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ret_err); end
    n_cmp++; if (level !== 8'd9) begin n_bad++; $display("FAIL reset_level: got %0d want 9", level); end
    rst_n = 1'b1; thresh = '0;
  endtask

  task automatic test_basic();
    int cyc;
    apply_reset();
    thresh = 0; en = '1; prio = '0; prio[3] = 8'd5;
    fire(8'h08, cyc);
    n_cmp++; if (cyc !== Lat) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (req_id !== 3'd3) begin n_bad++; $display("FAIL basic_id: got %0d want 3", req_id); end
    n_cmp++; if (req_prio !== 8'd5) begin n_bad++; $display("FAIL basic_prio: got %0d want 5", req_prio); end
    take();
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop: got %b want 0", req_valid); end
    n_cmp++; if (depth !== 3'd1) begin n_bad++; $display("FAIL basic_depth: got %0d want 1", depth); end
    n_cmp++; if (level !== 8'd5) begin n_bad++; $display("FAIL basic_level: got %0d want 5", level); end
    n_cmp++; if (pend[3] !== 1'b0) begin n_bad++; $display("FAIL basic_pend: got %b want 0", pend[3]); end
  endtask

  task automatic test_tie();
    int cyc;
    apply_reset();
    thresh = 0; en = '1; prio = '0; prio[2] = 8'd4; prio[6] = 8'd4;
    fire(8'h44, cyc);
    n_cmp++; if (req_valid !== 1'b1 || req_id !== 3'd6) begin
      n_bad++; $display("FAIL tie_equal: got v=%b id=%0d want v=1 id=6", req_valid, req_id);
    end
    apply_reset();
    prio[2] = 8'd7;
    fire(8'h44, cyc);
    n_cmp++; if (req_valid !== 1'b1 || req_id !== 3'd2 || req_prio !== 8'd7) begin
      n_bad++; $display("FAIL tie_higher: got v=%b id=%0d p=%0d want v=1 id=2 p=7", req_valid, req_id, req_prio);
    end
  endtask

  task automatic test_preempt();
    int cyc;
    apply_reset();
    thresh = 8'd1; en = '1; prio = '0; prio[3] = 8'd5; prio[1] = 8'd3;
    fire(8'h08, cyc);
    take();
    fire(8'h02, cyc);
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL preempt_block: got %b want 0", req_valid); end
    n_cmp++; if (pend[1] !== 1'b1) begin n_bad++; $display("FAIL preempt_pend: got %b want 1", pend[1]); end
    ret = 1'b1;
    @(negedge clk);
    ret = 1'b0;
    n_cmp++; if (level !== 8'd1 || depth !== 3'd0) begin
      n_bad++; $display("FAIL preempt_ret: got level=%0d depth=%0d want 1 0", level, depth);
    end
    @(negedge clk);
    n_cmp++; if (req_valid !== 1'b1 || req_id !== 3'd1 || req_prio !== 8'd3) begin
      n_bad++; $display("FAIL preempt_req: got v=%b id=%0d p=%0d want 1 1 3", req_valid, req_id, req_prio);
    end
  endtask

  task automatic test_nesting();
    int cyc;
    apply_reset();
    thresh = 0; en = '1; prio = '0;
    for (int i = 0; i < 5; i++) prio[i] = PW'(i + 1);
    for (int k = 0; k < 4; k++) begin
      fire(N'(1 << k), cyc);
      n_cmp++; if (req_valid !== 1'b1 || req_id !== 3'(k)) begin
        n_bad++; $display("FAIL nest_take%0d: got v=%b id=%0d want v=1 id=%0d", k, req_valid, req_id, k);
      end
      take();
    end
    n_cmp++; if (depth !== 3'd4 || level !== 8'd4) begin
      n_bad++; $display("FAIL nest_full: got depth=%0d level=%0d want 4 4", depth, level);
    end
    fire(8'h10, cyc);
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL nest_blocked: got %b want 0", req_valid); end
    ret = 1'b1;
    @(negedge clk);
    ret = 1'b0;
    n_cmp++; if (depth !== 3'd3 || level !== 8'd3) begin
      n_bad++; $display("FAIL nest_pop: got depth=%0d level=%0d want 3 3", depth, level);
    end
    @(negedge clk);
    n_cmp++; if (req_valid !== 1'b1 || req_id !== 3'd4 || req_prio !== 8'd5) begin
      n_bad++; $display("FAIL nest_fifth: got v=%b id=%0d p=%0d want 1 4 5", req_valid, req_id, req_prio);
    end
    take();
    n_cmp++; if (depth !== 3'd4 || level !== 8'd5) begin
      n_bad++; $display("FAIL nest_refill: got depth=%0d level=%0d want 4 5", depth, level);
    end
  endtask

  task automatic test_ret_take();
    int cyc;
    apply_reset();
    thresh = 0; en = '1; prio = '0; prio[0] = 8'd2; prio[1] = 8'd3; prio[2] = 8'd6;
    fire(8'h01, cyc); take();
    fire(8'h02, cyc); take();
    fire(8'h04, cyc);
    n_cmp++; if (req_valid !== 1'b1 || req_prio !== 8'd6) begin
      n_bad++; $display("FAIL rt_req: got v=%b p=%0d want 1 6", req_valid, req_prio);
    end
    ready = 1'b1; ret = 1'b1;
    @(negedge clk);
    ready = 1'b0; ret = 1'b0;
    n_cmp++; if (depth !== 3'd2 || level !== 8'd6) begin
      n_bad++; $display("FAIL rt_swap: got depth=%0d level=%0d want 2 6", depth, level);
    end
    n_cmp++; if (req_valid !== 1'b0 || ret_err !== 1'b0) begin
      n_bad++; $display("FAIL rt_flags: got v=%b err=%b want 0 0", req_valid, ret_err);
    end
  endtask

  task automatic test_ret_err();
    apply_reset();
    thresh = 8'd2;
    ret = 1'b1;
    @(negedge clk);
    ret = 1'b0;
    n_cmp++; if (ret_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", ret_err); end
    n_cmp++; if (depth !== 3'd0 || level !== 8'd2 || req_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_state: got depth=%0d level=%0d v=%b want 0 2 0", depth, level, req_valid);
    end
    @(negedge clk);
    n_cmp++; if (ret_err !== 1'b0) begin n_bad++; $display("FAIL err_single: got %b want 0", ret_err); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    apply_reset();
    thresh = 8'd2; en = '1; prio = '0; prio[5] = 8'd9;
    fire(8'h20, cyc);
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %b want 1", req_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (req_valid !== 1'b0 || req_id !== 3'd0 || req_prio !== 8'd0) begin
      n_bad++; $display("FAIL mid_req: got v=%b id=%0d p=%0d want 0 0 0", req_valid, req_id, req_prio);
    end
    n_cmp++; if (depth !== 3'd0 || pend !== 8'h00 || ret_err !== 1'b0 || level !== 8'd2) begin
      n_bad++; $display("FAIL mid_state: got depth=%0d pend=%h err=%b level=%0d want 0 00 0 2", depth, pend, ret_err, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_valid !== 1'b0) seen = 1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_quiet: got request want none"); end
  endtask

  task automatic test_random();
    logic [PW-1:0] e_level;
    apply_reset();
    for (int i = 0; i < N; i++) prio[i] = PW'($urandom_range(0, 7));
    thresh = PW'($urandom_range(0, 3));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e_level = (m_stack.size() == 0) ? thresh : m_stack[$];
      n_cmp++; if (req_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, req_valid, m_valid); end
      n_cmp++; if (req_id !== m_id) begin n_bad++; $display("FAIL rand_id c%0d: got %0d want %0d", c, req_id, m_id); end
      n_cmp++; if (req_prio !== m_prio) begin n_bad++; $display("FAIL rand_prio c%0d: got %0d want %0d", c, req_prio, m_prio); end
      n_cmp++; if (level !== e_level) begin n_bad++; $display("FAIL rand_level c%0d: got %0d want %0d", c, level, e_level); end
      n_cmp++; if (depth !== 3'(m_stack.size())) begin n_bad++; $display("FAIL rand_depth c%0d: got %0d want %0d", c, depth, m_stack.size()); end
      n_cmp++; if (pend !== m_pend) begin n_bad++; $display("FAIL rand_pend c%0d: got %h want %h", c, pend, m_pend); end
      n_cmp++; if (ret_err !== m_err) begin n_bad++; $display("FAIL rand_err c%0d: got %b want %b", c, ret_err, m_err); end
      irq   = N'($urandom & $urandom & $urandom);
      en    = N'($urandom | $urandom);
      ready = 1'($urandom_range(0, 1));
      ret   = ($urandom_range(0, 5) == 0);
    end
    irq = '0; ready = 1'b0; ret = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_preempt();
    test_nesting();
    test_ret_take();
    test_ret_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
